// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer encoder/decoder pair: widths, FSM
// states and the word-legality / popcount helpers.
package thermo_pkg;

  localparam int THERMO_W = 32'd15;
  localparam int BIN_W    = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // A word is legal when no set bit sits above a clear bit (no bubbles).
  function automatic logic thermo_legal(input logic [THERMO_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < THERMO_W; i++) begin
      if (w[i] && !w[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [BIN_W-1:0] thermo_popcount(input logic [THERMO_W-1:0] w);
    logic [BIN_W-1:0] n;
    n = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      n = n + {{(BIN_W-1){1'b0}}, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/thermo_sync.sv
// Two-flop vector synchronizer for the asynchronous thermometer input.
module thermo_sync #(
  parameter int WIDTH = 32'd15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/thermo_decoder.sv
// Synchronizes a thermometer word, rejects bubbled samples and accepts a
// binary count only after it has held for STABLE_SAMPLES sample ticks.
module thermo_decoder #(
  parameter int THERMO_W       = 32'd15,
  parameter int BIN_W          = 32'd4,
  parameter int STABLE_SAMPLES = 32'd4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [THERMO_W-1:0] thermo_in,
  input  logic                sample_en,
  output logic [BIN_W-1:0]    count,
  output logic                valid,
  output logic                update,
  output logic                bubble_err,
  output logic [7:0]          err_cnt
);

  import thermo_pkg::*;

  localparam logic [3:0] STABLE_L = 4'(STABLE_SAMPLES);

  logic [THERMO_W-1:0] s;
  logic                legal;
  logic [BIN_W-1:0]    decoded;
  logic [3:0]          scnt_inc;

  state_t           state, next_state;
  logic [BIN_W-1:0] cand, next_cand;
  logic [3:0]       scnt, next_scnt;
  logic [BIN_W-1:0] next_count;
  logic             next_valid, next_update, next_bubble;
  logic [7:0]       next_err;

  thermo_sync #(.WIDTH(THERMO_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (thermo_in),
    .q     (s)
  );

  assign legal    = thermo_legal(s);
  assign decoded  = thermo_popcount(s);
  assign scnt_inc = scnt + 4'd1;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= '0;
      scnt       <= 4'd0;
      count      <= '0;
      valid      <= 1'b0;
      update     <= 1'b0;
      bubble_err <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      state      <= next_state;
      cand       <= next_cand;
      scnt       <= next_scnt;
      count      <= next_count;
      valid      <= next_valid;
      update     <= next_update;
      bubble_err <= next_bubble;
      err_cnt    <= next_err;
    end
  end

  // Next-state logic; everything holds between sample ticks and update self-clears.
  always_comb begin
    next_state  = state;
    next_cand   = cand;
    next_scnt   = scnt;
    next_count  = count;
    next_valid  = valid;
    next_update = 1'b0;
    next_bubble = bubble_err;
    next_err    = err_cnt;
    if (sample_en) begin
      if (!legal) begin
        next_bubble = 1'b1;
        if (err_cnt != 8'hFF) next_err = err_cnt + 8'd1;
        else                  next_err = err_cnt;
        next_scnt = 4'd0;
        if (state == SETTLE) next_state = valid ? LOCKED : IDLE;
        else                 next_state = state;
      end else begin
        next_bubble = 1'b0;
        case (state)
          IDLE: begin
            next_cand  = decoded;
            next_scnt  = 4'd1;
            next_state = SETTLE;
          end
          SETTLE: begin
            if (decoded == cand) begin
              if (scnt_inc == STABLE_L) begin
                next_count  = cand;
                next_valid  = 1'b1;
                next_update = !valid || (cand != count);
                next_state  = LOCKED;
                next_scnt   = scnt_inc;
              end else begin
                next_scnt = scnt_inc;
              end
            end else begin
              next_cand = decoded;
              next_scnt = 4'd1;
            end
          end
          LOCKED: begin
            // A differing value re-qualifies while the old count stays published.
            if (decoded != count) begin
              next_cand  = decoded;
              next_scnt  = 4'd1;
              next_state = SETTLE;
            end else begin
              next_state = LOCKED;
            end
          end
          default: next_state = IDLE;
        endcase
      end
    end else begin
      next_state = state;
    end
  end

endmodule

// File: doc/thermo_decoder.md
# thermo_decoder

Receive-side counterpart to the 15-bit thermometer encoder. It takes a thermometer-coded word from an external source (LED-bar loopback or a switch bank) and synchronizes it into the `clk` domain. Each word is validated for bubbles, and the block recovers the 4-bit binary count only after the word has held steady for a programmable number of sample ticks. It sits at the input boundary of the counter/display design and is sampled by the existing frequency-divider enable tick.

## Interface
Parameters:
- `THERMO_W`, 15: thermometer word width; must equal 2^`BIN_W` − 1.
- `BIN_W`, 4: binary output width.
- `STABLE_SAMPLES`, 4: consecutive identical legal samples required to accept a value; legal range 2..15.

Ports:
- `clk`  in  1: single system clock.
- `reset`  in  1: asynchronous, active-high; clears all state including the synchronizer.
- `thermo_in`  in  `THERMO_W`: asynchronous thermometer input.
- `sample_en`  in  1: one-`clk` sample tick (for example `en_clk`); may be held high to sample every cycle.
- `count`  out  `BIN_W`: last accepted binary value.
- `valid`  out  1: a value has been accepted since reset.
- `update`  out  1: one-`clk` pulse on the edge where `count` takes a newly accepted value.
- `bubble_err`  out  1: the most recent sample was illegal.
- `err_cnt`  out  8: saturating count of illegal samples.

## Operation
- Synchronizer: two-flop vector synchronizer on `thermo_in`, clocked every `clk`, reset to 0. Its output is `s`.
- Legal word: for every i in 1..14, `s[i]` implies `s[i-1]`. Legal words decode to popcount(`s`). 15'h0000 decodes to 0 and 15'h7FFF decodes to 15.
- FSM: states IDLE, SETTLE, LOCKED. It advances only on cycles where `sample_en` = 1 and holds otherwise.
- IDLE, legal sample: `cand` ← decode, `scnt` ← 1, go to SETTLE.
- SETTLE, legal sample equal to `cand`: `scnt` ← `scnt` + 1. When the new value reaches `STABLE_SAMPLES`:
  - `count` ← `cand`, `valid` ← 1, go to LOCKED.
  - Pulse `update` if `valid` was 0 or `cand` ≠ old `count`.
- SETTLE, legal sample differing from `cand`: `cand` ← decode, `scnt` ← 1.
- LOCKED, legal sample equal to `count`: stay in LOCKED.
- LOCKED, legal sample differing from `count`: `cand` ← decode, `scnt` ← 1, go to SETTLE. `count` and `valid` hold.
- Illegal sample, any state:
  - `bubble_err` ← 1 and `err_cnt` increments, saturating at 255.
  - From SETTLE: discard progress; go to LOCKED if `valid`, else IDLE.
  - From IDLE or LOCKED: stay.
- Legal sample: `bubble_err` ← 0.
- `count` and `valid` never change except through acceptance or reset. `valid` never falls except on reset.

## Timing
- Reset values: `count` = 0, `valid` = 0, `update` = 0, `bubble_err` = 0, `err_cnt` = 0. The FSM is in IDLE and the synchronizer is cleared.
- Synchronizer latency: a change on `thermo_in` is visible in `s` after 2 `clk` edges.
- Acceptance latency: `count`, `valid` and `update` change on the same edge, which is the edge consuming the `STABLE_SAMPLES`-th agreeing sample.
  - With `sample_en` tied high: 2 + `STABLE_SAMPLES` cycles from the input change.
- `update` is high for exactly one `clk`, even if `sample_en` is held high.
- `bubble_err` and `err_cnt` update on the edge consuming the sample.
- Reset asserted mid-SETTLE clears everything immediately. Reacquisition needs the full latency again.

## Structure
- Shared package `thermo_pkg`:
  - Constants `THERMO_W` = 15 and `BIN_W` = 4.
  - FSM state encodings IDLE / SETTLE / LOCKED.
  - Legality-check and popcount functions, reusable by the encoder's bench.
- Sub-module `thermo_sync`: parameterized-width two-flop synchronizer with async active-high reset.
- The FSM, `scnt`, `cand`, `err_cnt` and the output registers live in `thermo_decoder`.

## Test plan
- Reset, then hold `thermo_in` = 15'h007F with `sample_en` every 4th `clk`. Required: `count` = 7 and `valid` = 1 on the 4th sample edge, a single 1-cycle `update`, `err_cnt` = 0.
- From LOCKED at 7, apply 15'h01FF for 3 samples, then return to 15'h007F. Required: `count` stays 7, no `update`, `valid` stays 1.
- Apply illegal 15'h0075 for 2 samples. Required: `bubble_err` = 1, `err_cnt` = 2, `count` unchanged. Then apply 15'h0FFF for 4 samples. Required: `count` = 12, `update` pulses, `bubble_err` = 0.
- Endpoints with `sample_en` tied high. 15'h0000 gives `count` = 0 with `update` (first acceptance) at cycle 6. 15'h7FFF gives `count` = 15.
- Assert `reset` after 2 agreeing samples of 15'h001F. Required: all outputs 0 asynchronously, and `count` = 5 only after 2 `clk` + 4 fresh samples.
- Apply 300 illegal samples. Required: `err_cnt` saturates at 255 and `count`/`valid` are unchanged.
